// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit 7-segment display.
// Patterns are written into a shadow bank. They reach the active bank only
// at a frame boundary, or straight away while idle, so a frame never shows
// a mix of old and new patterns. Every digit slot starts with BLANK cycles
// in which all pins are off, which keeps the previous digit from ghosting
// into the next one.
//
// Handshake: commit is a single-cycle request. It sets a pending flag, and
// any further commits merge into that flag until the copy is made.
// commit_ack pulses for one cycle, in the cycle after the copy edge. A
// commit that arrives on a copy edge is kept for the next copy.
module seven_seg_scan_ctrl #(
  parameter int NDIG       = 4,
  parameter int DWELL      = 160000,
  parameter int BLANK      = 1600,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [6:0]              wr_data,
  input  logic                    commit,
  output logic                    commit_ack,
  output logic [6:0]              segment,
  output logic [NDIG-1:0]         digit_en,
  output logic                    digit_tick,
  output logic                    frame_done,
  output logic [1:0]              dbg_state
);

  localparam int AW = $clog2(NDIG);
  localparam int CW = $clog2(DWELL);

  localparam logic [CW-1:0]   CNT_LAST       = CW'(DWELL - 1);
  localparam logic [CW-1:0]   CNT_BLANK_LAST = CW'(BLANK - 1);
  localparam logic [AW-1:0]   IDX_LAST       = AW'(NDIG - 1);
  localparam logic [6:0]      SEG_POL        = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NDIG-1:0] DIG_POL        = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [AW-1:0] idx, nxt_idx;
  logic [6:0]    shadow [NDIG];
  logic [6:0]    active [NDIG];
  logic          pending;
  logic          frame_edge;
  logic          copy_now;
  logic          wr_hit;

  // Copy points: the last cycle of the final digit, or any cycle spent idle.
  assign frame_edge = (state == S_ON) && (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign copy_now   = pending && ((state == S_IDLE) || frame_edge);
  assign wr_hit     = wr_en && (32'(wr_addr) < NDIG);
  assign dbg_state  = state;

  // Next-state sequencing of the slot counter and the digit index.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        nxt_idx = '0;
        if (en) nxt_state = S_BLANK;
      end
      S_BLANK: begin
        if (!en) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end else begin
          nxt_cnt = cnt + CW'(1);
          if (cnt == CNT_BLANK_LAST) nxt_state = S_ON;
        end
      end
      S_ON: begin
        if (!en) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end else if (cnt == CNT_LAST) begin
          nxt_state = S_BLANK;
          nxt_cnt   = '0;
          nxt_idx   = (idx == IDX_LAST) ? '0 : idx + AW'(1);
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
        nxt_idx   = '0;
      end
    endcase
  end

  // State, pattern banks and registered outputs; outputs come from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      commit_ack <= 1'b0;
      digit_tick <= 1'b0;
      frame_done <= 1'b0;
      segment    <= SEG_POL;
      digit_en   <= DIG_POL;
      for (int i = 0; i < NDIG; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;

      // The copy reads shadow before this edge's write, so a write on a copy
      // edge lands in shadow only.
      if (copy_now) begin
        for (int i = 0; i < NDIG; i++) active[i] <= shadow[i];
      end
      if (wr_hit) shadow[wr_addr] <= wr_data;

      if (copy_now)    pending <= commit;
      else if (commit) pending <= 1'b1;

      commit_ack <= copy_now;
      digit_tick <= (nxt_state == S_BLANK) && (nxt_cnt == '0);
      frame_done <= (nxt_state == S_ON) && (nxt_cnt == CNT_LAST) && (nxt_idx == IDX_LAST);

      // No copy edge is ever followed by ON, so the pre-copy bank is correct here.
      if (nxt_state == S_ON) begin
        segment  <= active[nxt_idx] ^ SEG_POL;
        digit_en <= (NDIG'(1) << nxt_idx) ^ DIG_POL;
      end else begin
        segment  <= SEG_POL;
        digit_en <= DIG_POL;
      end
    end
  end

endmodule
